// File: rtl/axi_lite_sram_rw.sv
// AXI4-Lite slave backed by an internal SRAM array with byte strobes,
// address decode (DECERR outside the window) and a configurable read latency.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   s_axi_ar*/s_axi_r*          read address / read data channels
//   s_axi_aw*/s_axi_w*/s_axi_b* write address / write data / write response
module axi_lite_sram_rw #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       DEPTH_LOG2 = 10,
    parameter int unsigned       RD_LAT     = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_axi_arvalid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    output logic                s_axi_arready,
    output logic                s_axi_rvalid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    input  logic                s_axi_rready,
    input  logic                s_axi_awvalid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    output logic                s_axi_awready,
    input  logic                s_axi_wvalid,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    output logic                s_axi_wready,
    output logic                s_axi_bvalid,
    output logic [1:0]          s_axi_bresp,
    input  logic                s_axi_bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = 4;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_NEED_W, W_NEED_AW, W_RESP} w_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // In range iff addr >= BASE_ADDR and the word index fits the array.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> (OFF_W + DEPTH_LOG2)) == '0);
    endfunction

    // Word index; low byte-offset bits are ignored.
    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off[OFF_W +: DEPTH_LOG2];
    endfunction

    // ---------------- read side ----------------
    r_state_t          r_state_q, r_state_d;
    logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
    logic [DATA_W-1:0] r_buf_q, r_buf_d;
    logic              r_err_q, r_err_d;
    logic              arready_d, rvalid_d;
    logic [DATA_W-1:0] rdata_d;
    logic [1:0]        rresp_d;
    logic              ar_ok_c;
    logic [DATA_W-1:0] ar_word_c;

    // Read next-state/outputs; the array is sampled at the AR handshake edge,
    // so a write committing on that same edge is not observed.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_buf_d   = r_buf_q;
        r_err_d   = r_err_q;
        arready_d = s_axi_arready;
        rvalid_d  = s_axi_rvalid;
        rdata_d   = s_axi_rdata;
        rresp_d   = s_axi_rresp;
        ar_ok_c   = addr_ok(s_axi_araddr);
        ar_word_c = ar_ok_c ? mem[addr_idx(s_axi_araddr)] : '0;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    arready_d = 1'b0;
                    r_buf_d   = ar_word_c;
                    r_err_d   = !ar_ok_c;
                    if (RD_LAT <= 1) begin
                        r_state_d = R_DATA;
                        rvalid_d  = 1'b1;
                        rdata_d   = ar_word_c;
                        rresp_d   = ar_ok_c ? OKAY : DECERR;
                    end else begin
                        r_state_d = R_WAIT;
                        r_cnt_d   = CNT_W'(RD_LAT - 1);
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt_q == CNT_W'(1)) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = r_buf_q;
                    rresp_d   = r_err_q ? DECERR : OKAY;
                end else begin
                    r_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    rdata_d   = '0;
                    rresp_d   = OKAY;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= R_IDLE;
            r_cnt_q       <= '0;
            r_buf_q       <= '0;
            r_err_q       <= 1'b0;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= OKAY;
        end else begin
            r_state_q     <= r_state_d;
            r_cnt_q       <= r_cnt_d;
            r_buf_q       <= r_buf_d;
            r_err_q       <= r_err_d;
            s_axi_arready <= arready_d;
            s_axi_rvalid  <= rvalid_d;
            s_axi_rdata   <= rdata_d;
            s_axi_rresp   <= rresp_d;
        end
    end

    // ---------------- write side ----------------
    w_state_t              w_state_q, w_state_d;
    logic [DEPTH_LOG2-1:0] aw_idx_q, aw_idx_d;
    logic                  aw_ok_q, aw_ok_d;
    logic [DATA_W-1:0]     w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  awready_d, wready_d, bvalid_d;
    logic [1:0]            bresp_d;
    logic                  aw_hs_c, w_hs_c, commit_c, wr_en_c, wr_ok_c;
    logic [DEPTH_LOG2-1:0] wr_idx_c;
    logic [DATA_W-1:0]     wr_data_c;
    logic [STRB_W-1:0]     wr_strb_c;

    // Write next-state/outputs; AW and W may arrive in either order.
    always_comb begin
        w_state_d = w_state_q;
        aw_idx_d  = aw_idx_q;
        aw_ok_d   = aw_ok_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        awready_d = s_axi_awready;
        wready_d  = s_axi_wready;
        bvalid_d  = s_axi_bvalid;
        bresp_d   = s_axi_bresp;
        aw_hs_c   = s_axi_awvalid && s_axi_awready;
        w_hs_c    = s_axi_wvalid && s_axi_wready;
        commit_c  = 1'b0;
        wr_ok_c   = addr_ok(s_axi_awaddr);
        wr_idx_c  = addr_idx(s_axi_awaddr);
        wr_data_c = s_axi_wdata;
        wr_strb_c = s_axi_wstrb;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c = 1'b1;
                end else if (aw_hs_c) begin
                    w_state_d = W_NEED_W;
                    aw_idx_d  = wr_idx_c;
                    aw_ok_d   = wr_ok_c;
                    awready_d = 1'b0;
                end else if (w_hs_c) begin
                    w_state_d = W_NEED_AW;
                    w_data_d  = s_axi_wdata;
                    w_strb_d  = s_axi_wstrb;
                    wready_d  = 1'b0;
                end
            end
            W_NEED_W: begin
                if (w_hs_c) begin
                    commit_c = 1'b1;
                    wr_idx_c = aw_idx_q;
                    wr_ok_c  = aw_ok_q;
                end
            end
            W_NEED_AW: begin
                if (aw_hs_c) begin
                    commit_c  = 1'b1;
                    wr_data_c = w_data_q;
                    wr_strb_c = w_strb_q;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit_c) begin
            w_state_d = W_RESP;
            awready_d = 1'b0;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok_c ? OKAY : DECERR;
        end
        wr_en_c = commit_c && wr_ok_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q     <= W_IDLE;
            aw_idx_q      <= '0;
            aw_ok_q       <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= OKAY;
        end else begin
            w_state_q     <= w_state_d;
            aw_idx_q      <= aw_idx_d;
            aw_ok_q       <= aw_ok_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            s_axi_awready <= awready_d;
            s_axi_wready  <= wready_d;
            s_axi_bvalid  <= bvalid_d;
            s_axi_bresp   <= bresp_d;
        end
    end

    // Byte-masked array write; suppressed while in reset, contents never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_c) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wr_strb_c[i]) begin
                    mem[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
                end
            end
        end
    end

endmodule
